// File: rtl/asrm_uart_tx_periph_if.sv
`default_nettype none
// ============================================================================
// Module      : asrm_uart_tx_periph_if
// Description : asrm system bus bundle between the CPU (master) and a
//               memory-mapped responder (slave). data_in carries CPU write
//               data and data_out carries the responder's read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface asrm_uart_tx_periph_if #(
    parameter int WORDSIZE = 16
);
    logic [WORDSIZE-1:0] addr;
    logic [WORDSIZE-1:0] data_in;
    logic                write_en;
    logic [WORDSIZE-1:0] data_out;

    modport master (
        output addr,
        output data_in,
        output write_en,
        input  data_out
    );

    modport slave (
        input  addr,
        input  data_in,
        input  write_en,
        output data_out
    );
endinterface
`default_nettype wire

// File: rtl/asrm_uart_tx_periph.sv
`default_nettype none
// ============================================================================
// Module      : asrm_uart_tx_periph
// Description : Memory-mapped 8N1 UART transmitter. The CPU pushes bytes
//               into a small TX FIFO; a serializer sends them LSB first at
//               a programmable bit period. Registers: TXDATA, STATUS,
//               DIVISOR, reserved. Read data is zero when not addressed.
// Revision    : 1.0 - initial release
// ============================================================================
module asrm_uart_tx_periph #(
    parameter int                  WORDSIZE        = 16,
    parameter logic [WORDSIZE-1:0] BASE_ADDR       = WORDSIZE'(16'hFF00),
    parameter int                  FIFO_DEPTH      = 4,
    parameter logic [WORDSIZE-1:0] DEFAULT_DIVISOR = WORDSIZE'(16)
) (
    input  wire logic              clk,
    input  wire logic              reset,
    asrm_uart_tx_periph_if.slave   bus,
    output logic                   tx
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    localparam logic [1:0] c_off_txdata  = 2'd0;
    localparam logic [1:0] c_off_status  = 2'd1;
    localparam logic [1:0] c_off_divisor = 2'd2;

    // FIFO storage and bookkeeping
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_ovf;

    // Configuration and serializer state
    logic [WORDSIZE-1:0] r_divisor;
    logic [1:0]          r_state;
    logic [WORDSIZE-1:0] r_timer;
    logic [WORDSIZE-1:0] r_bit_div;
    logic [7:0]          r_shift;
    logic [2:0]          r_bit_idx;
    logic                r_tx;
    logic [WORDSIZE-1:0] r_data_out;

    // Combinational decode and control
    logic                w_hit;
    logic [1:0]          w_offset;
    logic                w_wr;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_ovf_set;
    logic                w_timer_done;
    logic                w_pop;
    logic [WORDSIZE-1:0] w_eff_div;
    logic [7:0]          w_head;
    logic [WORDSIZE-1:0] w_status;
    logic [WORDSIZE-1:0] w_rdata;

    assign w_hit        = (bus.addr[WORDSIZE-1:2] == BASE_ADDR[WORDSIZE-1:2]);
    assign w_offset     = bus.addr[1:0];
    assign w_wr         = bus.write_en && w_hit;
    assign w_full       = (r_count == c_cnt_w'(FIFO_DEPTH));
    assign w_empty      = (r_count == '0);
    // Full is judged on the pre-edge count, so a same-cycle pop does not make room
    assign w_push       = w_wr && (w_offset == c_off_txdata) && !w_full;
    assign w_ovf_set    = w_wr && (w_offset == c_off_txdata) && w_full;
    assign w_timer_done = (r_timer == '0);
    // A byte leaves the FIFO when a frame starts from idle or chains after STOP
    assign w_pop        = !w_empty &&
                          ((r_state == c_st_idle) ||
                           ((r_state == c_st_stop) && w_timer_done));
    assign w_eff_div    = (r_divisor == '0) ? WORDSIZE'(1) : r_divisor;
    assign w_head       = r_mem[r_rd_ptr];

    assign bus.data_out = r_data_out;
    assign tx           = r_tx;

    // STATUS word assembly and read-data multiplexer
    always_comb begin
        w_status                  = '0;
        w_status[0]               = w_empty;
        w_status[1]               = w_full;
        w_status[2]               = (r_state != c_st_idle);
        w_status[3]               = r_ovf;
        w_status[4 +: c_cnt_w]    = r_count;
        w_rdata                   = '0;
        case (w_offset)
            c_off_status:  w_rdata = w_status;
            c_off_divisor: w_rdata = r_divisor;
            default:       w_rdata = '0;
        endcase
    end

    // FIFO payload storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.data_in[7:0];
        end
    end

    // FIFO pointers, occupancy count and overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_wr && (w_offset == c_off_status)) begin
                r_ovf <= 1'b0;
            end else if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // DIVISOR register and registered bus read data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_divisor  <= DEFAULT_DIVISOR;
            r_data_out <= '0;
        end else begin
            if (w_wr && (w_offset == c_off_divisor)) begin
                r_divisor <= bus.data_in;
            end
            r_data_out <= w_hit ? w_rdata : '0;
        end
    end

    // Serializer: start bit, 8 data bits LSB first, stop bit, chaining frames
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_timer   <= '0;
            r_bit_div <= '0;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_pop) begin
                        r_shift   <= w_head;
                        r_bit_div <= w_eff_div;
                        r_timer   <= w_eff_div - 1'b1;
                        r_tx      <= 1'b0;
                        r_state   <= c_st_start;
                    end
                end
                c_st_start: begin
                    if (w_timer_done) begin
                        r_timer   <= r_bit_div - 1'b1;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= c_st_data;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                c_st_data: begin
                    if (w_timer_done) begin
                        r_timer <= r_bit_div - 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= c_st_stop;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    if (w_timer_done) begin
                        if (w_pop) begin
                            // Next byte already waiting: no idle gap between frames
                            r_shift   <= w_head;
                            r_bit_div <= w_eff_div;
                            r_timer   <= w_eff_div - 1'b1;
                            r_tx      <= 1'b0;
                            r_state   <= c_st_start;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_asrm_uart_tx_periph.sv
`default_nettype none
// ============================================================================
// Module      : tb_asrm_uart_tx_periph
// Description : Self-checking bench for asrm_uart_tx_periph. Bus reads and
//               writes are checked against constants; the serial line is
//               logged every cycle and compared to an expected waveform
//               built from the frame format (start, 8 data LSB first, stop).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asrm_uart_tx_periph;

    localparam logic [15:0] c_BASE    = 16'hFF00;
    localparam logic [15:0] c_TXDATA  = c_BASE;
    localparam logic [15:0] c_STATUS  = c_BASE + 16'd1;
    localparam logic [15:0] c_DIVISOR = c_BASE + 16'd2;
    localparam logic [15:0] c_RSVD    = c_BASE + 16'd3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tx;

    int checks = 0;
    int errors = 0;

    logic tx_log[$];
    logic exp_q[$];

    asrm_uart_tx_periph_if #(.WORDSIZE(16)) bus ();

    asrm_uart_tx_periph #(
        .WORDSIZE        (16),
        .BASE_ADDR       (16'hFF00),
        .FIFO_DEPTH      (4),
        .DEFAULT_DIVISOR (16'd16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    // Line log: value of tx after each rising edge, one entry per cycle
    always @(negedge clk) tx_log.push_back(tx);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        bus.addr     = a;
        bus.data_in  = d;
        bus.write_en = 1'b1;
        tick();
        bus.write_en = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        bus.addr     = a;
        bus.write_en = 1'b0;
        tick();
        d = bus.data_out;
    endtask

    // Reference model: expected line levels, one entry per cycle
    function automatic void add_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
    endfunction

    function automatic void add_frame(input logic [7:0] b, input int div);
        int eff;
        eff = (div == 0) ? 1 : div;
        for (int i = 0; i < eff; i++) exp_q.push_back(1'b0);
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < eff; i++) exp_q.push_back(b[k]);
        for (int i = 0; i < eff; i++) exp_q.push_back(1'b1);
    endfunction

    task automatic test_reset();
        logic [15:0] rd;
        logic [15:0] exp_rd [4];
        exp_rd = '{16'h0000, 16'h0001, 16'h0010, 16'h0000};
        reset = 1'b1;
        repeat (2) begin
            tick();
            checks++;
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL reset_tx: tx=%b required 1", tx);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_read(c_BASE + 16'(i), rd);
            checks++;
            if (rd !== exp_rd[i]) begin
                errors++;
                $display("FAIL reset_read_off%0d: got %h required %h", i, rd, exp_rd[i]);
            end
            checks++;
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL reset_tx_idle: tx=%b required 1", tx);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [15:0] rd;
        int bad;
        bus_write(c_DIVISOR, 16'd4);
        bus_write(c_TXDATA, 16'h00A5);
        tx_log.delete();
        exp_q.delete();
        add_idle(1);
        add_frame(8'hA5, 4);
        add_idle(4);
        repeat (exp_q.size() + 2) tick();
        checks++;
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= tx_log.size() || tx_log[i] !== exp_q[i])) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL single_frame_line: cycle %0d tx=%b required %b", bad,
                     (bad < tx_log.size()) ? tx_log[bad] : 1'bx, exp_q[bad]);
        end
        bus_read(c_STATUS, rd);
        checks++;
        if (rd !== 16'h0001) begin
            errors++;
            $display("FAIL single_frame_status: got %h required 0001", rd);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] rd;
        int bad;
        bus_write(c_DIVISOR, 16'd100);
        exp_q.delete();
        for (int k = 1; k <= 6; k++) begin
            bus_write(c_TXDATA, 16'(k));
            if (k == 1) tx_log.delete();
        end
        bus_read(c_STATUS, rd);
        checks++;
        if (rd !== 16'h004E) begin
            errors++;
            $display("FAIL overflow_status: got %h required 004e", rd);
        end
        bus_write(c_STATUS, 16'h0000);
        bus_read(c_STATUS, rd);
        checks++;
        if (rd !== 16'h0046) begin
            errors++;
            $display("FAIL overflow_clear: got %h required 0046", rd);
        end
        add_idle(1);
        for (int k = 1; k <= 5; k++) add_frame(8'(k), 100);
        add_idle(50);
        repeat (exp_q.size() + 2) tick();
        checks++;
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= tx_log.size() || tx_log[i] !== exp_q[i])) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL overflow_line: cycle %0d tx=%b required %b", bad,
                     (bad < tx_log.size()) ? tx_log[bad] : 1'bx, exp_q[bad]);
        end
        bus_read(c_STATUS, rd);
        checks++;
        if (rd !== 16'h0001) begin
            errors++;
            $display("FAIL overflow_final_status: got %h required 0001", rd);
        end
    endtask

    task automatic test_divisor_zero();
        logic [15:0] rd;
        int bad;
        bus_write(c_DIVISOR, 16'd0);
        bus_write(c_TXDATA, 16'h00FF);
        tx_log.delete();
        exp_q.delete();
        add_idle(1);
        add_frame(8'hFF, 0);
        add_idle(5);
        repeat (exp_q.size() + 2) tick();
        checks++;
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= tx_log.size() || tx_log[i] !== exp_q[i])) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL div0_line: cycle %0d tx=%b required %b", bad,
                     (bad < tx_log.size()) ? tx_log[bad] : 1'bx, exp_q[bad]);
        end
        bus_read(c_DIVISOR, rd);
        checks++;
        if (rd !== 16'h0000) begin
            errors++;
            $display("FAIL div0_readback: got %h required 0000", rd);
        end
        bus_read(c_STATUS, rd);
        checks++;
        if (rd !== 16'h0001) begin
            errors++;
            $display("FAIL div0_status: got %h required 0001", rd);
        end
    endtask

    task automatic test_decode();
        logic [15:0] rd;
        int bad;
        bus_write(c_DIVISOR, 16'h1234);
        bus_read(c_DIVISOR, rd);
        checks++;
        if (rd !== 16'h1234) begin
            errors++;
            $display("FAIL decode_div_rw: got %h required 1234", rd);
        end
        bus_read(c_BASE - 16'd1, rd);
        checks++;
        if (rd !== 16'h0000) begin
            errors++;
            $display("FAIL decode_below: got %h required 0000", rd);
        end
        bus_read(c_RSVD, rd);
        checks++;
        if (rd !== 16'h0000) begin
            errors++;
            $display("FAIL decode_reserved: got %h required 0000", rd);
        end
        bus_write(c_BASE + 16'd4, 16'h0055);
        bus_write(c_RSVD, 16'h0077);
        bus_write(c_BASE - 16'd1, 16'h0099);
        bus_write(c_BASE + 16'd6, 16'h0000);
        tx_log.delete();
        bus_read(c_STATUS, rd);
        checks++;
        if (rd !== 16'h0001) begin
            errors++;
            $display("FAIL decode_status: got %h required 0001", rd);
        end
        bus_read(c_DIVISOR, rd);
        checks++;
        if (rd !== 16'h1234) begin
            errors++;
            $display("FAIL decode_div_kept: got %h required 1234", rd);
        end
        repeat (10) tick();
        checks++;
        bad = -1;
        foreach (tx_log[i]) if (bad < 0 && tx_log[i] !== 1'b1) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL decode_line: cycle %0d tx=%b required 1", bad, tx_log[bad]);
        end
    endtask

    task automatic test_divisor_latch();
        logic [7:0] b1;
        logic [7:0] b2;
        int bad;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        bus_write(c_DIVISOR, 16'd3);
        bus_write(c_TXDATA, {8'h00, b1});
        tx_log.delete();
        exp_q.delete();
        bus_write(c_TXDATA, {8'h00, b2});
        bus_write(c_DIVISOR, 16'd5);
        add_idle(1);
        add_frame(b1, 3);
        add_frame(b2, 5);
        add_idle(5);
        repeat (exp_q.size() + 2) tick();
        checks++;
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= tx_log.size() || tx_log[i] !== exp_q[i])) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL div_latch_line: cycle %0d tx=%b required %b", bad,
                     (bad < tx_log.size()) ? tx_log[bad] : 1'bx, exp_q[bad]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd;
        logic [7:0]  b;
        int bad;
        int div;
        int n;
        for (int it = 0; it < 6; it++) begin
            div = int'($urandom_range(0, 6));
            n   = int'($urandom_range(1, 4));
            bus_write(c_DIVISOR, 16'(div));
            exp_q.delete();
            add_idle(1);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                bus_write(c_TXDATA, {8'h00, b});
                if (k == 0) tx_log.delete();
                add_frame(b, div);
            end
            add_idle(4);
            repeat (exp_q.size() + 2) tick();
            checks++;
            bad = -1;
            for (int i = 0; i < exp_q.size(); i++)
                if (bad < 0 && (i >= tx_log.size() || tx_log[i] !== exp_q[i])) bad = i;
            if (bad >= 0) begin
                errors++;
                $display("FAIL b2b_line it%0d div%0d n%0d: cycle %0d tx=%b required %b",
                         it, div, n, bad,
                         (bad < tx_log.size()) ? tx_log[bad] : 1'bx, exp_q[bad]);
            end
            bus_read(c_STATUS, rd);
            checks++;
            if (rd !== 16'h0001) begin
                errors++;
                $display("FAIL b2b_status it%0d: got %h required 0001", it, rd);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] rd;
        int bad;
        bus_write(c_DIVISOR, 16'd4);
        bus_write(c_TXDATA, 16'h0055);
        bus_write(c_TXDATA, 16'h003C);
        bus_write(c_TXDATA, 16'h000F);
        // Frame started one edge after the first push; 16 more edges lands in bit 3
        repeat (16) tick();
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL midreset_bit3: tx=%b required 0", tx);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL midreset_tx: tx=%b required 1", tx);
        end
        reset = 1'b0;
        tx_log.delete();
        bus_read(c_STATUS, rd);
        checks++;
        if (rd !== 16'h0001) begin
            errors++;
            $display("FAIL midreset_status: got %h required 0001", rd);
        end
        bus_read(c_DIVISOR, rd);
        checks++;
        if (rd !== 16'h0010) begin
            errors++;
            $display("FAIL midreset_divisor: got %h required 0010", rd);
        end
        repeat (100) tick();
        checks++;
        bad = -1;
        foreach (tx_log[i]) if (bad < 0 && tx_log[i] !== 1'b1) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL midreset_line: cycle %0d tx=%b required 1", bad, tx_log[bad]);
        end
    endtask

    initial begin
        bus.addr     = 16'h0000;
        bus.data_in  = 16'h0000;
        bus.write_en = 1'b0;
        test_reset();
        test_single_frame();
        test_overflow();
        test_divisor_zero();
        test_decode();
        test_divisor_latch();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
